// File: rtl/servo_pkg.sv
// Shared constants, a clog2 helper and the per-channel state type for the
// multi-channel servo PWM generator.
package servo_pkg;

    localparam int unsigned N_CH_DEF       = 4;
    localparam int unsigned PERIOD_CYC_DEF = 1_000_000;
    localparam int unsigned MIN_CYC_DEF    = 25_000;
    localparam int unsigned MAX_CYC_DEF    = 125_000;
    localparam int unsigned CENTER_DEF     = (MIN_CYC_DEF + MAX_CYC_DEF) / 2;
    localparam int unsigned POS_W_DEF      = 8;
    localparam int unsigned SLEW_CYC_DEF   = 2_500;

    // Channel widths are carried at a fixed storage width; bits above
    // clog2(PERIOD_CYC) are always zero and fold away in synthesis.
    localparam int unsigned ST_W = 32;

    typedef logic [ST_W-1:0] ch_cnt_t;

    typedef struct packed {
        ch_cnt_t cur;
        ch_cnt_t tgt;
    } ch_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Command port of servo_pwm_multi: valid/ready handshake plus error pulse.
interface servo_pwm_multi_if #(
    parameter int unsigned CH_W  = servo_pkg::clog2(servo_pkg::N_CH_DEF),
    parameter int unsigned POS_W = servo_pkg::POS_W_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CH_W-1:0]  cmd_ch;
    logic [POS_W-1:0] cmd_pos;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_ch, cmd_pos,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_pos,
        output cmd_ready, cmd_err
    );
endinterface

// File: rtl/servo_slew_ch.sv
// One servo channel: target/current width, per-frame slew step, pulse
// compare and at-target flag.
module servo_slew_ch
    import servo_pkg::*;
#(
    parameter int unsigned CENTER   = CENTER_DEF,
    parameter int unsigned SLEW_CYC = SLEW_CYC_DEF
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    boundary_i,
    input  logic    wr_en_i,
    input  ch_cnt_t wr_width_i,
    input  ch_cnt_t fcnt_i,
    output logic    pwm_o,
    output logic    at_target_o
);

    localparam ch_cnt_t       CENTER_W = ch_cnt_t'(CENTER);
    localparam logic [ST_W:0] SLEW_X   = (ST_W+1)'(SLEW_CYC);

    ch_state_t     st_q;
    ch_state_t     st_d;
    logic          pwm_q;
    logic          at_q;
    logic [ST_W:0] cur_x_s;
    logic [ST_W:0] tgt_x_s;
    logic [ST_W:0] dist_s;
    logic [ST_W:0] step_s;

    // Slew step one bit wider than the state, clamped to tgt so it never wraps.
    always_comb begin
        cur_x_s = {1'b0, st_q.cur};
        tgt_x_s = {1'b0, st_q.tgt};
        dist_s  = (tgt_x_s >= cur_x_s) ? (tgt_x_s - cur_x_s) : (cur_x_s - tgt_x_s);
        step_s  = cur_x_s;
        if ((SLEW_CYC == 32'd0) || (dist_s <= SLEW_X)) begin
            step_s = tgt_x_s;
        end else if (tgt_x_s > cur_x_s) begin
            step_s = cur_x_s + SLEW_X;
            step_s = (step_s > tgt_x_s) ? tgt_x_s : step_s;
        end else begin
            step_s = cur_x_s - SLEW_X;
            step_s = ((step_s < tgt_x_s) || (step_s > cur_x_s)) ? tgt_x_s : step_s;
        end

        st_d = st_q;
        if (boundary_i) begin
            st_d.cur = step_s[ST_W-1:0];
        end else begin
            st_d.cur = st_q.cur;
        end
        if (wr_en_i) begin
            st_d.tgt = wr_width_i;
        end else begin
            st_d.tgt = st_q.tgt;
        end
    end

    // State, pulse and flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q  <= '{cur: CENTER_W, tgt: CENTER_W};
            pwm_q <= 1'b0;
            at_q  <= 1'b1;
        end else begin
            st_q  <= st_d;
            pwm_q <= (fcnt_i < st_q.cur);
            at_q  <= (st_q.cur == st_q.tgt);
        end
    end

    assign pwm_o       = pwm_q;
    assign at_target_o = at_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: shared frame counter, command
// decode/scale into per-channel targets, and N_CH slew-limited channels.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int unsigned N_CH       = N_CH_DEF,
    parameter int unsigned PERIOD_CYC = PERIOD_CYC_DEF,
    parameter int unsigned MIN_CYC    = MIN_CYC_DEF,
    parameter int unsigned MAX_CYC    = MAX_CYC_DEF,
    parameter int unsigned POS_W      = POS_W_DEF,
    parameter int unsigned SLEW_CYC   = SLEW_CYC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    servo_pwm_multi_if.slave  cmd_if,
    output logic [N_CH-1:0]   pwm_o,
    output logic [N_CH-1:0]   at_target_o,
    output logic              frame_tick_o
);

    localparam int unsigned      CNT_W  = clog2(PERIOD_CYC);
    localparam int unsigned      SCALE  = (MAX_CYC - MIN_CYC) / ((2 ** POS_W) - 1);
    localparam int unsigned      CENTER = (MIN_CYC + MAX_CYC) / 2;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD_CYC - 1);

    if (MAX_CYC >= PERIOD_CYC) begin : g_bad_max
        $error("servo_pwm_multi: MAX_CYC must be below PERIOD_CYC");
    end
    if ((N_CH < 1) || (N_CH > 16)) begin : g_bad_nch
        $error("servo_pwm_multi: N_CH must be 1..16");
    end

    logic [CNT_W-1:0] fcnt_q;
    logic [CNT_W-1:0] fcnt_d;
    logic             tick_q;
    logic             err_q;
    logic             err_d;
    logic             boundary_s;
    logic             accept_s;
    logic             ch_ok_s;
    ch_cnt_t          width_s;
    logic [N_CH-1:0]  wr_en_s;

    assign cmd_if.cmd_ready = ~rst_i;

    // Frame counter, command decode and position-to-width scaling.
    always_comb begin
        boundary_s = (fcnt_q == LAST);
        fcnt_d     = boundary_s ? '0 : (fcnt_q + CNT_W'(1));
        accept_s   = cmd_if.cmd_valid & cmd_if.cmd_ready;
        ch_ok_s    = (32'(cmd_if.cmd_ch) < N_CH);
        err_d      = accept_s & ~ch_ok_s;
        width_s    = ch_cnt_t'(MIN_CYC) + ch_cnt_t'(cmd_if.cmd_pos) * ch_cnt_t'(SCALE);
        wr_en_s    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            wr_en_s[i] = accept_s & ch_ok_s & (32'(cmd_if.cmd_ch) == i);
        end
    end

    // Shared counter and one-cycle status pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fcnt_q <= '0;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            tick_q <= boundary_s;
            err_q  <= err_d;
        end
    end

    assign cmd_if.cmd_err = err_q;
    assign frame_tick_o   = tick_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        servo_slew_ch #(
            .CENTER   (CENTER),
            .SLEW_CYC (SLEW_CYC)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .boundary_i  (boundary_s),
            .wr_en_i     (wr_en_s[g]),
            .wr_width_i  (width_s),
            .fcnt_i      (ch_cnt_t'(fcnt_q)),
            .pwm_o       (pwm_o[g]),
            .at_target_o (at_target_o[g])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi with shortened frames: 200-cycle period,
// widths 25..125, 4-bit positions (scale 6), slew 10; a second instance runs unlimited slew.
module tb_servo_pwm_multi;
    import servo_pkg::*;

    localparam int PER = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] pwm_a, at_a;
    logic [1:0] pwm_b, at_b;
    logic       tick_a, tick_b;

    always #5 clk = ~clk;

    servo_pwm_multi_if #(.CH_W(3), .POS_W(4)) if_a ();
    servo_pwm_multi_if #(.CH_W(1), .POS_W(4)) if_b ();

    servo_pwm_multi #(.N_CH(5), .PERIOD_CYC(200), .MIN_CYC(25), .MAX_CYC(125),
                      .POS_W(4), .SLEW_CYC(10)) dut_a (
        .clk_i(clk), .rst_i(rst), .cmd_if(if_a),
        .pwm_o(pwm_a), .at_target_o(at_a), .frame_tick_o(tick_a));

    servo_pwm_multi #(.N_CH(2), .PERIOD_CYC(200), .MIN_CYC(25), .MAX_CYC(125),
                      .POS_W(4), .SLEW_CYC(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .cmd_if(if_b),
        .pwm_o(pwm_b), .at_target_o(at_b), .frame_tick_o(tick_b));

    typedef struct {
        bit         inj;
        logic [2:0] ch;
        logic [3:0] pos;
        int         w[5];
        logic [4:0] at;
    } vec_t;

    vec_t       tbl[10];
    int         n_chk = 0;
    int         n_err = 0;
    int         wa[5];
    int         wb[2];
    logic [4:0] at_end_a;
    logic [1:0] at_end_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_row(input int r, input bit inj, input logic [2:0] ch, input logic [3:0] pos,
                           input int w0, input int w1, input int w2, input int w3, input int w4,
                           input logic [4:0] at);
        tbl[r].inj  = inj;
        tbl[r].ch   = ch;
        tbl[r].pos  = pos;
        tbl[r].w[0] = w0;
        tbl[r].w[1] = w1;
        tbl[r].w[2] = w2;
        tbl[r].w[3] = w3;
        tbl[r].w[4] = w4;
        tbl[r].at   = at;
    endtask

    // Sync to the next FRAME_TICK and count high cycles over one frame;
    // optionally issue one command on dut_a at frame cycle 'inj'.
    task automatic measure(input int inj, input logic [2:0] ch, input logic [3:0] pos);
        int guard;
        @(negedge clk);
        if_a.cmd_valid = 1'b0;
        guard = 0;
        while (tick_a !== 1'b1 && guard < 2 * PER) begin
            @(negedge clk);
            if_a.cmd_valid = 1'b0;
            guard++;
        end
        chk("frame_tick_seen", {31'd0, guard < 2 * PER}, 32'd1);
        for (int i = 0; i < 5; i++) wa[i] = 0;
        for (int i = 0; i < 2; i++) wb[i] = 0;
        for (int k = 0; k < PER; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if_a.cmd_valid = 1'b0;
            end
            for (int i = 0; i < 5; i++) wa[i] += int'(pwm_a[i]);
            for (int i = 0; i < 2; i++) wb[i] += int'(pwm_b[i]);
            if (k == inj) begin
                if_a.cmd_valid = 1'b1;
                if_a.cmd_ch    = ch;
                if_a.cmd_pos   = pos;
            end
        end
        at_end_a = at_a;
        at_end_b = at_b;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int final_w[5];
        int tick_at;

        if_a.cmd_valid = 1'b0; if_a.cmd_ch = 3'd0; if_a.cmd_pos = 4'd0;
        if_b.cmd_valid = 1'b0; if_b.cmd_ch = 1'd0; if_b.cmd_pos = 4'd0;

        // Consecutive frames; a command at frame start shows up one frame later.
        set_row(0, 1'b1, 3'd1, 4'd15,  75,  75, 75, 75,  75, 5'b11101);
        set_row(1, 1'b0, 3'd0, 4'd0,   75,  85, 75, 75,  75, 5'b11101);
        set_row(2, 1'b0, 3'd0, 4'd0,   75,  95, 75, 75,  75, 5'b11101);
        set_row(3, 1'b0, 3'd0, 4'd0,   75, 105, 75, 75,  75, 5'b11101);
        set_row(4, 1'b1, 3'd3, 4'd0,   75, 115, 75, 75,  75, 5'b10111);
        set_row(5, 1'b1, 3'd3, 4'd8,   75, 115, 75, 65,  75, 5'b10111);
        set_row(6, 1'b1, 3'd4, 4'd13,  75, 115, 75, 73,  75, 5'b01111);
        set_row(7, 1'b1, 3'd0, 4'd7,   75, 115, 75, 73,  85, 5'b01110);
        set_row(8, 1'b0, 3'd0, 4'd0,   67, 115, 75, 73,  95, 5'b01111);
        set_row(9, 1'b0, 3'd0, 4'd0,   67, 115, 75, 73, 103, 5'b11111);
        final_w = '{67, 115, 75, 73, 103};

        // Reset held for 5 cycles.
        repeat (3) @(negedge clk);
        chk("rst_pwm_a", pwm_a, 0);
        chk("rst_at_a", at_a, 5'b11111);
        chk("rst_tick", tick_a, 0);
        chk("rst_err", if_a.cmd_err, 0);
        chk("rst_ready", if_a.cmd_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", if_a.cmd_ready, 1);

        for (int r = 0; r < 10; r++) begin
            measure(tbl[r].inj ? 0 : -1, tbl[r].ch, tbl[r].pos);
            for (int i = 0; i < 5; i++)
                chk($sformatf("row%0d_w%0d", r, i), wa[i], tbl[r].w[i]);
            chk($sformatf("row%0d_at", r), at_end_a, tbl[r].at);
            if (r == 0) begin
                chk("b_center_w0", wb[0], 75);
                chk("b_center_w1", wb[1], 75);
            end
        end

        // Out-of-range channels pulse CMD_ERR once and change nothing.
        @(negedge clk);
        if_a.cmd_valid = 1'b1; if_a.cmd_ch = 3'd5; if_a.cmd_pos = 4'd3;
        @(negedge clk);
        if_a.cmd_valid = 1'b0;
        chk("err_ch5_pulse", if_a.cmd_err, 1);
        @(negedge clk);
        chk("err_ch5_clear", if_a.cmd_err, 0);
        if_a.cmd_valid = 1'b1; if_a.cmd_ch = 3'd7; if_a.cmd_pos = 4'd15;
        @(negedge clk);
        if_a.cmd_valid = 1'b0;
        chk("err_ch7_pulse", if_a.cmd_err, 1);
        measure(-1, 3'd0, 4'd0);
        for (int i = 0; i < 5; i++) chk($sformatf("err_nochange_w%0d", i), wa[i], final_w[i]);
        chk("err_nochange_at", at_end_a, 5'b11111);

        // Two commands to ch2 in one frame: the second (pos 9 -> 79) wins.
        @(negedge clk);
        if_a.cmd_valid = 1'b1; if_a.cmd_ch = 3'd2; if_a.cmd_pos = 4'd15;
        @(negedge clk);
        if_a.cmd_pos = 4'd9;
        @(negedge clk);
        if_a.cmd_valid = 1'b0;
        measure(-1, 3'd0, 4'd0);
        chk("last_wins_w2", wa[2], 79);
        chk("last_wins_at", at_end_a, 5'b11111);

        // Command mid-pulse leaves the current frame intact.
        measure(20, 3'd0, 4'd15);
        chk("midpulse_w0", wa[0], 67);
        chk("midpulse_at", at_end_a, 5'b11110);

        // Command on the boundary cycle takes effect one frame later.
        measure(PER - 1, 3'd2, 4'd0);
        chk("bnd0_w0", wa[0], 77);
        chk("bnd0_w2", wa[2], 79);
        chk("bnd0_at", at_end_a, 5'b11110);
        measure(-1, 3'd0, 4'd0);
        chk("bnd1_w0", wa[0], 87);
        chk("bnd1_w2", wa[2], 79);
        chk("bnd1_at", at_end_a, 5'b11010);
        measure(-1, 3'd0, 4'd0);
        chk("bnd2_w0", wa[0], 97);
        chk("bnd2_w2", wa[2], 69);
        chk("bnd2_at", at_end_a, 5'b11010);

        // Reset in the middle of a move and mid-pulse.
        @(negedge clk);
        repeat (30) @(negedge clk);
        chk("pre_rst_pwm0", pwm_a[0], 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_pwm_a", pwm_a, 0);
        chk("rst_mid_pwm_b", pwm_b, 0);
        chk("rst_mid_at", at_a, 5'b11111);
        chk("rst_mid_ready", if_a.cmd_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) wa[i] = 0;
        for (int i = 0; i < 2; i++) wb[i] = 0;
        tick_at = -1;
        for (int k = 1; k <= PER; k++) begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) wa[i] += int'(pwm_a[i]);
            for (int i = 0; i < 2; i++) wb[i] += int'(pwm_b[i]);
            if (tick_a === 1'b1 && tick_at < 0) tick_at = k;
        end
        chk("post_rst_tick_at", tick_at, PER);
        for (int i = 0; i < 5; i++) chk($sformatf("post_rst_w%0d", i), wa[i], 75);
        chk("post_rst_b_w0", wb[0], 75);

        // Unlimited slew: ch0 -> 25 and ch1 -> 115 in a single frame.
        if_b.cmd_valid = 1'b1; if_b.cmd_ch = 1'd0; if_b.cmd_pos = 4'd0;
        @(negedge clk);
        if_b.cmd_ch = 1'd1; if_b.cmd_pos = 4'd15;
        @(negedge clk);
        if_b.cmd_valid = 1'b0;
        measure(-1, 3'd0, 4'd0);
        chk("imm_b_w0", wb[0], 25);
        chk("imm_b_w1", wb[1], 115);
        chk("imm_b_at", at_end_b, 2'b11);
        chk("imm_a_w1", wa[1], 75);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
